// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780-style 4-bit bus responder.
package lcd_pkg;

   // Leading-one command codes; a byte decodes as the highest code it reaches.
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_HOME    = 8'h02;
   localparam logic [7:0] CMD_ENTRY   = 8'h04;
   localparam logic [7:0] CMD_DISPLAY = 8'h08;
   localparam logic [7:0] CMD_SHIFT   = 8'h10;
   localparam logic [7:0] CMD_FUNC    = 8'h20;
   localparam logic [7:0] CMD_CGRAM   = 8'h40;
   localparam logic [7:0] CMD_DDRAM   = 8'h80;

   localparam logic [7:0] CHAR_SPACE  = 8'h20;

   typedef enum logic {
      NIB_HIGH = 1'b0,
      NIB_LOW  = 1'b1
   } nib_state_t;

endpackage

// File: rtl/lcd_nibble_sync.sv
// Bus synchronizer, en falling-edge detect and high/low nibble pairing with
// a timeout that drops a stranded high nibble.
module lcd_nibble_sync
   import lcd_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int NIBBLE_TIMEOUT = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_en,
   input  logic       lcd_rs,
   input  logic [3:0] lcd_data,
   output logic       byte_valid,
   output logic       byte_rs,
   output logic [7:0] byte_data,
   output logic       fault
);

   localparam int CW = $clog2(NIBBLE_TIMEOUT + 1);

   logic [SYNC_STAGES-1:0]      en_sync;
   logic [SYNC_STAGES-1:0]      rs_sync;
   logic [SYNC_STAGES-1:0][3:0] data_sync;
   logic                        en_prev;
   logic                        fall;
   logic                        rs_s;
   logic [3:0]                  data_s;

   nib_state_t    state, state_n;
   logic [3:0]    hi, hi_n;
   logic          rs_hi, rs_hi_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          valid_n, rs_n, fault_n;
   logic [7:0]    data_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         en_sync   <= '0;
         rs_sync   <= '0;
         data_sync <= '0;
         en_prev   <= 1'b0;
      end else begin
         en_sync   <= {en_sync[SYNC_STAGES-2:0], lcd_en};
         rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
         data_sync <= {data_sync[SYNC_STAGES-2:0], lcd_data};
         en_prev   <= en_sync[SYNC_STAGES-1];
      end
   end

   // rs and data come from the same synced stage as the en sample.
   assign fall   = en_prev & ~en_sync[SYNC_STAGES-1];
   assign rs_s   = rs_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   always_comb begin
      state_n = state;
      hi_n    = hi;
      rs_hi_n = rs_hi;
      cnt_n   = cnt;
      valid_n = 1'b0;
      rs_n    = byte_rs;
      data_n  = byte_data;
      fault_n = 1'b0;
      case (state)
         NIB_HIGH: begin
            if (fall) begin
               hi_n    = data_s;
               rs_hi_n = rs_s;
               cnt_n   = '0;
               state_n = NIB_LOW;
            end
         end
         NIB_LOW: begin
            if (fall) begin
               valid_n = 1'b1;
               rs_n    = rs_s;
               data_n  = {hi, data_s};
               fault_n = (rs_hi != rs_s);
               state_n = NIB_HIGH;
            end else if (cnt == CW'(NIBBLE_TIMEOUT - 1)) begin
               fault_n = 1'b1;
               state_n = NIB_HIGH;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = NIB_HIGH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= NIB_HIGH;
         hi         <= '0;
         rs_hi      <= 1'b0;
         cnt        <= '0;
         byte_valid <= 1'b0;
         byte_rs    <= 1'b0;
         byte_data  <= '0;
         fault      <= 1'b0;
      end else begin
         state      <= state_n;
         hi         <= hi_n;
         rs_hi      <= rs_hi_n;
         cnt        <= cnt_n;
         byte_valid <= valid_n;
         byte_rs    <= rs_n;
         byte_data  <= data_n;
         fault      <= fault_n;
      end
   end

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style 4-bit bus responder: command decode, cursor, 2x16 DDRAM
// image with a registered read port, and the space-fill clear sweep.
module lcd_bus_receiver
   import lcd_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int LINE_LEN       = 16,
   parameter int DDRAM_DEPTH    = 32,
   parameter int NIBBLE_TIMEOUT = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_rs,
   input  logic       lcd_en,
   input  logic [3:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       byte_valid,
   output logic       byte_rs,
   output logic [7:0] byte_data,
   output logic [4:0] cursor_addr,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       inc_mode,
   output logic       two_line,
   output logic       busy,
   output logic       err
);

   logic       nb_valid, nb_rs, nb_fault;
   logic [7:0] nb_data;

   lcd_nibble_sync #(
      .SYNC_STAGES    (SYNC_STAGES),
      .NIBBLE_TIMEOUT (NIBBLE_TIMEOUT)
   ) u_nibble (
      .clk        (clk),
      .rst        (rst),
      .lcd_en     (lcd_en),
      .lcd_rs     (lcd_rs),
      .lcd_data   (lcd_data),
      .byte_valid (nb_valid),
      .byte_rs    (nb_rs),
      .byte_data  (nb_data),
      .fault      (nb_fault)
   );

   logic [7:0] mem [DDRAM_DEPTH];
   logic [4:0] sweep_cnt;
   logic       sweep_pend;

   logic [4:0] cursor_n, cur_inc, cur_dec, ddram_addr;
   logic       display_n, cursor_vis_n, blink_n, inc_n, two_line_n;
   logic       wr_en, clear_cmd, cmd_err;

   assign cur_inc    = (cursor_addr == 5'(DDRAM_DEPTH - 1)) ? 5'd0 : cursor_addr + 5'd1;
   assign cur_dec    = (cursor_addr == 5'd0) ? 5'(DDRAM_DEPTH - 1) : cursor_addr - 5'd1;
   assign ddram_addr = (nb_data[6] ? 5'(LINE_LEN) : 5'd0)
                     + 5'(int'(nb_data[3:0]) % LINE_LEN);

   // Decode lands on the same edge that publishes byte_valid.
   always_comb begin
      cursor_n     = cursor_addr;
      display_n    = display_on;
      cursor_vis_n = cursor_on;
      blink_n      = blink_on;
      inc_n        = inc_mode;
      two_line_n   = two_line;
      wr_en        = 1'b0;
      clear_cmd    = 1'b0;
      cmd_err      = 1'b0;
      if (nb_valid) begin
         if (!nb_rs && nb_data == CMD_CLEAR) begin
            // Clear is honoured even mid-sweep so it can restart it.
            cursor_n  = '0;
            inc_n     = 1'b1;
            clear_cmd = 1'b1;
         end else if (busy) begin
            cmd_err = 1'b1;
         end else if (nb_rs) begin
            wr_en    = 1'b1;
            cursor_n = inc_mode ? cur_inc : cur_dec;
         end else if (nb_data >= CMD_DDRAM) begin
            cursor_n = ddram_addr;
            cmd_err  = (nb_data[5:4] != 2'b00);
         end else if (nb_data >= CMD_CGRAM) begin
         end else if (nb_data >= CMD_FUNC) begin
            two_line_n = nb_data[3];
         end else if (nb_data >= CMD_SHIFT) begin
         end else if (nb_data >= CMD_DISPLAY) begin
            display_n    = nb_data[2];
            cursor_vis_n = nb_data[1];
            blink_n      = nb_data[0];
         end else if (nb_data >= CMD_ENTRY) begin
            inc_n = nb_data[1];
         end else if (nb_data >= CMD_HOME) begin
            cursor_n = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cursor_addr <= '0;
         display_on  <= 1'b0;
         cursor_on   <= 1'b0;
         blink_on    <= 1'b0;
         inc_mode    <= 1'b1;
         two_line    <= 1'b0;
         byte_valid  <= 1'b0;
         byte_rs     <= 1'b0;
         byte_data   <= '0;
         err         <= 1'b0;
      end else begin
         cursor_addr <= cursor_n;
         display_on  <= display_n;
         cursor_on   <= cursor_vis_n;
         blink_on    <= blink_n;
         inc_mode    <= inc_n;
         two_line    <= two_line_n;
         byte_valid  <= nb_valid;
         byte_rs     <= nb_rs;
         byte_data   <= nb_data;
         err         <= nb_fault | cmd_err;
      end
   end

   // Sweep is armed during reset and launches on the first released cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy       <= 1'b0;
         sweep_cnt  <= '0;
         sweep_pend <= 1'b1;
      end else if (sweep_pend || clear_cmd) begin
         busy       <= 1'b1;
         sweep_cnt  <= '0;
         sweep_pend <= 1'b0;
      end else if (busy) begin
         sweep_cnt <= sweep_cnt + 5'd1;
         if (sweep_cnt == 5'(DDRAM_DEPTH - 1))
            busy <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (busy)
            mem[sweep_cnt] <= CHAR_SPACE;
         else if (wr_en)
            mem[cursor_addr] <= nb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: scenario tasks plus a randomized
// run against a display model kept at the command level.
module tb_lcd_bus_receiver;

   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lcd_rs = 1'b0;
   logic       lcd_en = 1'b0;
   logic [3:0] lcd_data = 4'h0;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data;
   logic       byte_valid, byte_rs;
   logic [7:0] byte_data;
   logic [4:0] cursor_addr;
   logic       display_on, cursor_on, blink_on, inc_mode, two_line, busy, err;

   int n_cmp = 0;
   int n_bad = 0;
   int bv_cnt = 0;
   int err_cnt = 0;
   int busy_cnt = 0;

   // display model
   logic [7:0] ref_mem [32];
   int         ref_cur = 0;
   logic       ref_inc = 1'b1;
   logic       ref_disp = 1'b0;
   logic       ref_two = 1'b0;

   lcd_bus_receiver #(
      .SYNC_STAGES(SYNC), .LINE_LEN(16), .DDRAM_DEPTH(32), .NIBBLE_TIMEOUT(20000)
   ) dut (
      .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_data(lcd_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .byte_valid(byte_valid), .byte_rs(byte_rs),
      .byte_data(byte_data), .cursor_addr(cursor_addr), .display_on(display_on),
      .cursor_on(cursor_on), .blink_on(blink_on), .inc_mode(inc_mode), .two_line(two_line),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (byte_valid === 1'b1) bv_cnt <= bv_cnt + 1;
      if (err === 1'b1) err_cnt <= err_cnt + 1;
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_nibble(input logic rs, input logic [3:0] nib, input int en_len, input int gap);
      lcd_rs = rs;
      lcd_data = nib;
      lcd_en = 1'b1;
      tick(en_len);
      lcd_en = 1'b0;
      tick(gap);
   endtask

   // Sends a byte and reports when byte_valid showed up after the low-nibble fall.
   task automatic send_byte(input logic rs, input logic [7:0] b, input int en_len, input int gap,
                            input int tail, output int lat, output logic [7:0] seen,
                            output logic seen_rs);
      send_nibble(rs, b[7:4], en_len, gap);
      lcd_rs = rs;
      lcd_data = b[3:0];
      lcd_en = 1'b1;
      tick(en_len);
      lcd_en = 1'b0;
      lat = -1;
      seen = 8'h00;
      seen_rs = 1'b0;
      for (int k = 1; k <= tail; k++) begin
         @(negedge clk);
         if (byte_valid === 1'b1 && lat < 0) begin
            lat = k;
            seen = byte_data;
            seen_rs = byte_rs;
         end
      end
   endtask

   task automatic read_mem(input int a, output logic [7:0] d);
      rd_addr = 5'(a);
      tick(1);
      d = rd_data;
   endtask

   task automatic model_byte(input logic rs, input logic [7:0] b);
      if (rs) begin
         ref_mem[ref_cur] = b;
         ref_cur = (ref_cur + (ref_inc ? 1 : 31)) % 32;
      end else if (b >= 8'h80) begin
         ref_cur = (b[6] ? 16 : 0) + (int'(b[3:0]) % 16);
      end else if (b >= 8'h40) begin
      end else if (b >= 8'h20) begin
         ref_two = b[3];
      end else if (b >= 8'h10) begin
      end else if (b >= 8'h08) begin
         ref_disp = b[2];
      end else if (b >= 8'h04) begin
         ref_inc = b[1];
      end else if (b >= 8'h02) begin
         ref_cur = 0;
      end else if (b == 8'h01) begin
         ref_cur = 0;
         ref_inc = 1'b1;
         for (int i = 0; i < 32; i++) ref_mem[i] = 8'h20;
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      int b0;
      rst = 1'b0;
      tick(3);
      n_cmp++;
      if (cursor_addr !== 5'd0) begin n_bad++; $display("FAIL reset_cursor: got %0d want 0", cursor_addr); end
      n_cmp++;
      if ({display_on, cursor_on, blink_on, inc_mode, two_line} !== 5'b00010) begin
         n_bad++; $display("FAIL reset_flags: got %b want 00010", {display_on, cursor_on, blink_on, inc_mode, two_line});
      end
      n_cmp++;
      if ({byte_valid, byte_rs, busy, err} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_strobes: got %b want 0000", {byte_valid, byte_rs, busy, err});
      end
      n_cmp++;
      if ({byte_data, rd_data} !== 16'h0000) begin
         n_bad++; $display("FAIL reset_data: got %h want 0000", {byte_data, rd_data});
      end
      b0 = busy_cnt;
      rst = 1'b1;
      tick(40);
      n_cmp++;
      if (busy_cnt - b0 != 32) begin n_bad++; $display("FAIL reset_sweep_len: got %0d want 32", busy_cnt - b0); end
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h20;
      for (int i = 0; i < 32; i++) begin
         read_mem(i, d);
         n_cmp++;
         if (d !== 8'h20) begin n_bad++; $display("FAIL reset_ddram[%0d]: got %h want 20", i, d); end
      end
   endtask

   task automatic test_initiator();
      logic [7:0] cmds [6];
      logic [8*12-1:0] msg;
      logic [7:0] d, c, seen;
      logic srs;
      int lat, e0;
      cmds = '{8'h02, 8'h28, 8'h0C, 8'h01, 8'h06, 8'h80};
      msg = "UEDB BY SIMS";
      e0 = err_cnt;
      for (int i = 0; i < 6; i++) begin
         send_byte(1'b0, cmds[i], 100, 100, 3000, lat, seen, srs);
         model_byte(1'b0, cmds[i]);
      end
      for (int i = 0; i < 12; i++) begin
         c = msg[8*(11-i) +: 8];
         send_byte(1'b1, c, 100, 100, 3000, lat, seen, srs);
         model_byte(1'b1, c);
      end
      n_cmp++;
      if (cursor_addr !== 5'd12) begin n_bad++; $display("FAIL init_cursor: got %0d want 12", cursor_addr); end
      n_cmp++;
      if ({display_on, two_line} !== 2'b11) begin n_bad++; $display("FAIL init_flags: got %b want 11", {display_on, two_line}); end
      n_cmp++;
      if (err_cnt != e0) begin n_bad++; $display("FAIL init_err: got %0d pulses want 0", err_cnt - e0); end
      for (int i = 0; i < 32; i++) begin
         read_mem(i, d);
         c = (i < 12) ? msg[8*(11-i) +: 8] : 8'h20;
         n_cmp++;
         if (d !== c) begin n_bad++; $display("FAIL init_ddram[%0d]: got %h want %h", i, d, c); end
      end
   endtask

   task automatic test_addr_wrap();
      logic [7:0] d, seen;
      logic srs;
      int lat, e0;
      e0 = err_cnt;
      send_byte(1'b0, 8'hC5, 5, 5, 8, lat, seen, srs); model_byte(1'b0, 8'hC5);
      send_byte(1'b1, 8'h58, 5, 5, 8, lat, seen, srs); model_byte(1'b1, 8'h58);
      n_cmp++;
      if (cursor_addr !== 5'd22) begin n_bad++; $display("FAIL wrap_cursor22: got %0d want 22", cursor_addr); end
      read_mem(21, d);
      n_cmp++;
      if (d !== 8'h58) begin n_bad++; $display("FAIL wrap_ddram21: got %h want 58", d); end
      send_byte(1'b0, 8'hCF, 5, 5, 8, lat, seen, srs); model_byte(1'b0, 8'hCF);
      send_byte(1'b1, 8'h41, 5, 5, 8, lat, seen, srs); model_byte(1'b1, 8'h41);
      send_byte(1'b1, 8'h42, 5, 5, 8, lat, seen, srs); model_byte(1'b1, 8'h42);
      read_mem(31, d);
      n_cmp++;
      if (d !== 8'h41) begin n_bad++; $display("FAIL wrap_ddram31: got %h want 41", d); end
      read_mem(0, d);
      n_cmp++;
      if (d !== 8'h42) begin n_bad++; $display("FAIL wrap_ddram0: got %h want 42", d); end
      n_cmp++;
      if (cursor_addr !== 5'd1) begin n_bad++; $display("FAIL wrap_cursor1: got %0d want 1", cursor_addr); end
      n_cmp++;
      if (err_cnt != e0) begin n_bad++; $display("FAIL wrap_err: got %0d pulses want 0", err_cnt - e0); end
   endtask

   task automatic test_decrement();
      logic [7:0] d, seen;
      logic srs;
      int lat;
      send_byte(1'b0, 8'h04, 5, 5, 8, lat, seen, srs); model_byte(1'b0, 8'h04);
      send_byte(1'b0, 8'h80, 5, 5, 8, lat, seen, srs); model_byte(1'b0, 8'h80);
      send_byte(1'b1, 8'h5A, 5, 5, 8, lat, seen, srs); model_byte(1'b1, 8'h5A);
      read_mem(0, d);
      n_cmp++;
      if (d !== 8'h5A) begin n_bad++; $display("FAIL dec_ddram0: got %h want 5a", d); end
      n_cmp++;
      if (cursor_addr !== 5'd31) begin n_bad++; $display("FAIL dec_cursor: got %0d want 31", cursor_addr); end
      n_cmp++;
      if (inc_mode !== 1'b0) begin n_bad++; $display("FAIL dec_inc_mode: got %b want 0", inc_mode); end
   endtask

   task automatic test_random();
      logic [7:0] b, d, seen;
      logic rs, srs;
      int lat, kind, e0;
      e0 = err_cnt;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            rs = 1'b0;
            b = {6'b000001, 1'($urandom_range(0, 1)), 1'b0};
         end else if (kind == 1) begin
            rs = 1'b0;
            b = {1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom_range(0, 15))};
         end else begin
            rs = 1'b1;
            b = 8'($urandom_range(32, 126));
         end
         send_byte(rs, b, $urandom_range(3, 8), $urandom_range(3, 8), 8, lat, seen, srs);
         model_byte(rs, b);
         n_cmp++;
         if (lat != LAT || seen !== b || srs !== rs) begin
            n_bad++;
            $display("FAIL rand_byte[%0d]: got lat=%0d data=%h rs=%b want lat=%0d data=%h rs=%b",
                     n, lat, seen, srs, LAT, b, rs);
         end
         n_cmp++;
         if (32'(cursor_addr) !== ref_cur) begin
            n_bad++; $display("FAIL rand_cursor[%0d]: got %0d want %0d", n, cursor_addr, ref_cur);
         end
      end
      n_cmp++;
      if (inc_mode !== ref_inc) begin n_bad++; $display("FAIL rand_inc_mode: got %b want %b", inc_mode, ref_inc); end
      n_cmp++;
      if (err_cnt != e0) begin n_bad++; $display("FAIL rand_err: got %0d pulses want 0", err_cnt - e0); end
      for (int i = 0; i < 32; i++) begin
         read_mem(i, d);
         n_cmp++;
         if (d !== ref_mem[i]) begin n_bad++; $display("FAIL rand_ddram[%0d]: got %h want %h", i, d, ref_mem[i]); end
      end
   endtask

   task automatic test_half_byte();
      logic [7:0] d, seen;
      logic srs;
      int lat, e0, v0, at;
      e0 = err_cnt;
      v0 = bv_cnt;
      send_nibble(1'b1, 4'h4, 5, 5);
      tick(20010);
      n_cmp++;
      if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL half_err: got %0d pulses want 1", err_cnt - e0); end
      n_cmp++;
      if (bv_cnt != v0) begin n_bad++; $display("FAIL half_valid: got %0d bytes want 0", bv_cnt - v0); end
      at = ref_cur;
      send_byte(1'b1, 8'h41, 5, 5, 8, lat, seen, srs);
      model_byte(1'b1, 8'h41);
      n_cmp++;
      if (seen !== 8'h41 || lat != LAT) begin n_bad++; $display("FAIL half_resync_byte: got %h lat %0d want 41 lat %0d", seen, lat, LAT); end
      read_mem(at, d);
      n_cmp++;
      if (d !== 8'h41) begin n_bad++; $display("FAIL half_resync_ddram[%0d]: got %h want 41", at, d); end
   endtask

   task automatic test_busy();
      logic [7:0] d, seen;
      logic srs;
      int lat, e0, v0, b0;
      e0 = err_cnt;
      v0 = bv_cnt;
      b0 = busy_cnt;
      send_byte(1'b0, 8'h01, 5, 5, 5, lat, seen, srs);
      model_byte(1'b0, 8'h01);
      send_byte(1'b1, 8'h51, 5, 5, 5, lat, seen, srs);
      n_cmp++;
      if (seen !== 8'h51) begin n_bad++; $display("FAIL busy_q_emitted: got %h want 51", seen); end
      tick(40);
      n_cmp++;
      if (busy_cnt - b0 != 32) begin n_bad++; $display("FAIL busy_len: got %0d want 32", busy_cnt - b0); end
      n_cmp++;
      if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL busy_err: got %0d pulses want 1", err_cnt - e0); end
      n_cmp++;
      if (bv_cnt - v0 != 2) begin n_bad++; $display("FAIL busy_valid: got %0d bytes want 2", bv_cnt - v0); end
      n_cmp++;
      if (cursor_addr !== 5'd0 || inc_mode !== 1'b1) begin
         n_bad++; $display("FAIL busy_cursor: got %0d/%b want 0/1", cursor_addr, inc_mode);
      end
      for (int i = 0; i < 32; i++) begin
         read_mem(i, d);
         n_cmp++;
         if (d !== ref_mem[i]) begin n_bad++; $display("FAIL busy_ddram[%0d]: got %h want %h", i, d, ref_mem[i]); end
      end
   endtask

   task automatic test_reset_mid_byte();
      logic [7:0] d;
      int e0, v0, b0;
      // restore non-default state so the reset has something to clear
      v0 = 0;
      e0 = err_cnt;
      send_nibble(1'b0, 4'h2, 5, 5);
      send_nibble(1'b0, 4'h8, 5, 5);
      send_nibble(1'b0, 4'h0, 5, 5);
      send_nibble(1'b0, 4'hF, 5, 10);
      n_cmp++;
      if ({display_on, cursor_on, blink_on, two_line} !== 4'b1111) begin
         n_bad++; $display("FAIL rmb_setup: got %b want 1111", {display_on, cursor_on, blink_on, two_line});
      end
      v0 = bv_cnt;
      send_nibble(1'b1, 4'h5, 10, 10);
      rst = 1'b0;
      tick(1);
      n_cmp++;
      if ({display_on, cursor_on, blink_on, inc_mode, two_line, busy, byte_valid, err} !== 8'b00010000) begin
         n_bad++;
         $display("FAIL rmb_reset_state: got %b want 00010000",
                  {display_on, cursor_on, blink_on, inc_mode, two_line, busy, byte_valid, err});
      end
      n_cmp++;
      if (cursor_addr !== 5'd0 || rd_data !== 8'h00) begin
         n_bad++; $display("FAIL rmb_reset_regs: got %0d/%h want 0/00", cursor_addr, rd_data);
      end
      b0 = busy_cnt;
      rst = 1'b1;
      tick(40);
      n_cmp++;
      if (busy_cnt - b0 != 32) begin n_bad++; $display("FAIL rmb_sweep_len: got %0d want 32", busy_cnt - b0); end
      send_nibble(1'b1, 4'h5, 10, 20);
      n_cmp++;
      if (bv_cnt != v0) begin n_bad++; $display("FAIL rmb_no_valid: got %0d bytes want 0", bv_cnt - v0); end
      n_cmp++;
      if (err_cnt != e0) begin n_bad++; $display("FAIL rmb_no_err: got %0d pulses want 0", err_cnt - e0); end
      read_mem(0, d);
      n_cmp++;
      if (d !== 8'h20) begin n_bad++; $display("FAIL rmb_ddram0: got %h want 20", d); end
   endtask

   initial begin
      test_reset();
      test_initiator();
      test_addr_wrap();
      test_decrement();
      test_random();
      test_half_byte();
      test_busy();
      test_reset_mid_byte();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
